// File: rtl/lorenz_seq.sv
// lorenz_seq: run controller for the fixed-point Lorenz solver.
// Latches a run configuration, holds the solver at its initial conditions,
// issues rate-divided step strobes and emits decimated (x,y,z) samples
// over a lossless valid/ready port.
module lorenz_seq #(
    parameter int WIDTH = 27,
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [WIDTH-1:0] cfg_sigma,
    input  logic signed [WIDTH-1:0] cfg_beta,
    input  logic signed [WIDTH-1:0] cfg_rho,
    input  logic signed [WIDTH-1:0] cfg_dt,
    input  logic signed [WIDTH-1:0] cfg_x0,
    input  logic signed [WIDTH-1:0] cfg_y0,
    input  logic signed [WIDTH-1:0] cfg_z0,
    input  logic [DIV_W-1:0]        cfg_step_div,
    input  logic [CNT_W-1:0]        cfg_num_steps,
    input  logic [15:0]             cfg_sample_every,
    input  logic signed [WIDTH-1:0] sol_x,
    input  logic signed [WIDTH-1:0] sol_y,
    input  logic signed [WIDTH-1:0] sol_z,
    output logic                    sol_reset,
    output logic                    sol_step,
    output logic signed [WIDTH-1:0] sol_sigma,
    output logic signed [WIDTH-1:0] sol_beta,
    output logic signed [WIDTH-1:0] sol_rho,
    output logic signed [WIDTH-1:0] sol_dt,
    output logic signed [WIDTH-1:0] sol_x0,
    output logic signed [WIDTH-1:0] sol_y0,
    output logic signed [WIDTH-1:0] sol_z0,
    output logic                    smp_valid,
    input  logic                    smp_ready,
    output logic signed [WIDTH-1:0] smp_x,
    output logic signed [WIDTH-1:0] smp_y,
    output logic signed [WIDTH-1:0] smp_z,
    output logic [CNT_W-1:0]        smp_idx,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        step_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]      DEC_ONE = 16'd1;

    // Control state
    state_t            state_q, state_d;
    logic              init_q, init_d;      // second INIT cycle marker
    logic [DIV_W-1:0]  div_q, div_d;        // step-rate divider
    logic [15:0]       dec_q, dec_d;        // steps since last capture
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // steps issued this run
    logic              cap_q, cap_d;        // capture strobe issued, solver result not yet registered
    logic              vld_q, vld_d;        // sample pending on the output port

    // Sample holding registers
    logic [WIDTH-1:0]  sx_q, sx_d;
    logic [WIDTH-1:0]  sy_q, sy_d;
    logic [WIDTH-1:0]  sz_q, sz_d;
    logic [CNT_W-1:0]  idx_q, idx_d;

    // Latched run configuration
    logic [WIDTH-1:0]  p_sigma_q, p_beta_q, p_rho_q, p_dt_q;
    logic [WIDTH-1:0]  p_x0_q, p_y0_q, p_z0_q;
    logic [DIV_W-1:0]  p_div_q;
    logic [CNT_W-1:0]  p_num_q;
    logic [15:0]       p_se_q;              // decimation, already forced to >= 1

    // Decode signals
    logic              start_ok;
    logic              handshake;
    logic              step_ok;
    logic              is_cap;
    logic              is_last;
    logic [CNT_W-1:0]  cnt_inc;
    logic [15:0]       dec_inc;

    // Start is only honoured when not busy; abort in the same cycle wins.
    always_comb begin
        start_ok  = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
        handshake = vld_q && smp_ready;
        // A step needs the divider expired and the sample path empty.
        step_ok   = (state_q == S_RUN) && (div_q == '0) && !vld_q && !cap_q;
        cnt_inc   = cnt_q + CNT_ONE;
        dec_inc   = dec_q + DEC_ONE;
        is_cap    = (dec_inc >= p_se_q);
        is_last   = (p_num_q != '0) && (cnt_inc == p_num_q);
    end

    // Next-state, counters and sample path.
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        div_d   = div_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        cap_d   = 1'b0;
        vld_d   = vld_q && !handshake;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sz_d    = sz_q;
        idx_d   = idx_q;

        // Solver state is valid the cycle after a capture strobe.
        if (cap_q) begin
            sx_d  = sol_x;
            sy_d  = sol_y;
            sz_d  = sol_z;
            idx_d = cnt_q;
            vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_INIT;
                    init_d  = 1'b0;
                    cnt_d   = '0;
                    div_d   = '0;
                    dec_d   = '0;
                end
            end
            S_INIT: begin
                // Preload divider so the first step lands step_div cycles into RUN.
                div_d = p_div_q;
                if (init_q) begin
                    state_d = S_RUN;
                end else begin
                    init_d = 1'b1;
                end
            end
            S_RUN: begin
                if (step_ok) begin
                    cnt_d = cnt_inc;
                    div_d = p_div_q;
                    if (is_cap) begin
                        dec_d = '0;
                        cap_d = 1'b1;
                    end else begin
                        dec_d = dec_inc;
                    end
                    if (is_last) begin
                        state_d = is_cap ? S_DRAIN : S_DONE;
                    end
                end else if (div_q != '0) begin
                    div_d = div_q - DIV_ONE;
                end
            end
            S_DRAIN: begin
                if (handshake) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards any pending or in-flight sample.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cap_d   = 1'b0;
            vld_d   = 1'b0;
        end
    end

    // Control and sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            init_q  <= 1'b0;
            div_q   <= '0;
            dec_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            vld_q   <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            sz_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            div_q   <= div_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            vld_q   <= vld_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sz_q    <= sz_d;
            idx_q   <= idx_d;
        end
    end

    // Run configuration, captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_sigma_q <= '0;
            p_beta_q  <= '0;
            p_rho_q   <= '0;
            p_dt_q    <= '0;
            p_x0_q    <= '0;
            p_y0_q    <= '0;
            p_z0_q    <= '0;
            p_div_q   <= '0;
            p_num_q   <= '0;
            p_se_q    <= '0;
        end else if (start_ok) begin
            p_sigma_q <= cfg_sigma;
            p_beta_q  <= cfg_beta;
            p_rho_q   <= cfg_rho;
            p_dt_q    <= cfg_dt;
            p_x0_q    <= cfg_x0;
            p_y0_q    <= cfg_y0;
            p_z0_q    <= cfg_z0;
            p_div_q   <= cfg_step_div;
            p_num_q   <= cfg_num_steps;
            p_se_q    <= (cfg_sample_every == '0) ? DEC_ONE : cfg_sample_every;
        end
    end

    // Output mapping.
    always_comb begin
        sol_reset  = (state_q == S_IDLE) || (state_q == S_INIT);
        sol_step   = step_ok;
        sol_sigma  = p_sigma_q;
        sol_beta   = p_beta_q;
        sol_rho    = p_rho_q;
        sol_dt     = p_dt_q;
        sol_x0     = p_x0_q;
        sol_y0     = p_y0_q;
        sol_z0     = p_z0_q;
        smp_valid  = vld_q;
        smp_x      = sx_q;
        smp_y      = sy_q;
        smp_z      = sz_q;
        smp_idx    = idx_q;
        busy       = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
        done       = (state_q == S_DONE);
        step_count = cnt_q;
    end

endmodule

// File: tb/tb_lorenz_seq.sv
// Bench for lorenz_seq: a trivial additive solver stub, a negedge event
// monitor, and expectations computed from the run rules in closed form.
module tb_lorenz_seq;
    localparam int W  = 27;
    localparam int DW = 16;
    localparam int CW = 32;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort;
    logic [W-1:0] cfg_sigma, cfg_beta, cfg_rho, cfg_dt, cfg_x0, cfg_y0, cfg_z0;
    logic [DW-1:0] cfg_step_div;
    logic [CW-1:0] cfg_num_steps;
    logic [15:0]   cfg_sample_every;
    logic [W-1:0]  sol_x, sol_y, sol_z;
    logic          sol_reset, sol_step;
    logic [W-1:0]  sol_sigma, sol_beta, sol_rho, sol_dt, sol_x0, sol_y0, sol_z0;
    logic          smp_valid, smp_ready;
    logic [W-1:0]  smp_x, smp_y, smp_z;
    logic [CW-1:0] smp_idx, step_count;
    logic          busy, done;

    lorenz_seq #(.WIDTH(W), .DIV_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_sigma(cfg_sigma), .cfg_beta(cfg_beta), .cfg_rho(cfg_rho), .cfg_dt(cfg_dt),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_z0(cfg_z0),
        .cfg_step_div(cfg_step_div), .cfg_num_steps(cfg_num_steps),
        .cfg_sample_every(cfg_sample_every),
        .sol_x(sol_x), .sol_y(sol_y), .sol_z(sol_z),
        .sol_reset(sol_reset), .sol_step(sol_step),
        .sol_sigma(sol_sigma), .sol_beta(sol_beta), .sol_rho(sol_rho), .sol_dt(sol_dt),
        .sol_x0(sol_x0), .sol_y0(sol_y0), .sol_z0(sol_z0),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z), .smp_idx(smp_idx),
        .busy(busy), .done(done), .step_count(step_count)
    );

    // Solver stub: each step adds sigma/beta/rho, so state after k steps is x0 + k*sigma.
    always_ff @(posedge clk) begin
        if (sol_reset) begin
            sol_x <= sol_x0; sol_y <= sol_y0; sol_z <= sol_z0;
        end else if (sol_step) begin
            sol_x <= sol_x + sol_sigma; sol_y <= sol_y + sol_beta; sol_z <= sol_z + sol_rho;
        end
    end

    // Ready generation: forced low, random, or always high.
    logic rdy_lo = 1'b0, rdy_rand = 1'b0, rnd_bit = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign smp_ready = rdy_lo ? 1'b0 : (rdy_rand ? rnd_bit : 1'b1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: step strobes, handshakes, done rising edges, protocol violations.
    int            step_t[$];
    logic [CW-1:0] hs_idx[$];
    logic [W-1:0]  hs_x[$], hs_y[$], hs_z[$];
    int            done_t[$];
    int            viol = 0;
    logic          done_prev = 1'b0;
    always @(negedge clk) begin
        if (sol_step) step_t.push_back(cyc);
        if (sol_step && smp_valid) viol++;
        if (smp_valid && smp_ready) begin
            hs_idx.push_back(smp_idx);
            hs_x.push_back(smp_x); hs_y.push_back(smp_y); hs_z.push_back(smp_z);
        end
        if (done && !done_prev) done_t.push_back(cyc);
        done_prev = done;
    end

    int n_chk = 0, n_fail = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin ok = 1'b1; break; end
            tick();
        end
        check({"done_reached_", nm}, ok, 1);
    endtask

    logic [63:0] rx0, ry0, rz0, rsg, rbt, rrh;
    task automatic rand_cfg();
        rx0 = 64'($urandom) & MASK; ry0 = 64'($urandom) & MASK; rz0 = 64'($urandom) & MASK;
        rsg = 64'($urandom) & MASK; rbt = 64'($urandom) & MASK; rrh = 64'($urandom) & MASK;
        cfg_x0 = rx0[W-1:0]; cfg_y0 = ry0[W-1:0]; cfg_z0 = rz0[W-1:0];
        cfg_sigma = rsg[W-1:0]; cfg_beta = rbt[W-1:0]; cfg_rho = rrh[W-1:0];
        cfg_dt = W'($urandom);
    endtask

    // Check sample n of the current run (starting at queue offset bh) against the model.
    task automatic check_sample(input string nm, input int pos, input logic [63:0] idx);
        check({"smp_idx_", nm}, hs_idx[pos], idx);
        check({"smp_x_", nm}, hs_x[pos], (rx0 + idx * rsg) & MASK);
        check({"smp_y_", nm}, hs_y[pos], (ry0 + idx * rbt) & MASK);
        check({"smp_z_", nm}, hs_z[pos], (rz0 + idx * rrh) & MASK);
    endtask

    // One complete bounded run with optional exact timing expectations.
    task automatic do_run(input int div, input int num, input int se, input bit rr,
                          input bit tchk, input string nm);
        int bs, bh, bd, bv, t, se_e, ncap, tk, f;
        rand_cfg();
        cfg_step_div = DW'(div); cfg_num_steps = CW'(num); cfg_sample_every = 16'(se);
        rdy_rand = rr;
        bs = step_t.size(); bh = hs_idx.size(); bd = done_t.size(); bv = viol;
        t = cyc;
        pulse_start();
        wait_done(nm);
        tick(); tick(); tick();
        se_e = (se == 0) ? 1 : se;
        ncap = num / se_e;
        check({"nsteps_", nm}, step_t.size() - bs, num);
        check({"nsamples_", nm}, hs_idx.size() - bh, ncap);
        for (int i = 0; i < ncap && bh + i < hs_idx.size(); i++)
            check_sample(nm, bh + i, 64'((i + 1) * se_e));
        if (tchk) begin
            tk = t + 3 + div;
            for (int k = 1; k <= num && bs + k - 1 < step_t.size(); k++) begin
                if (k > 1) begin
                    // After a capture step the next step needs at least 3 cycles.
                    int gap = div + 1;
                    if (((k - 1) % se_e) == 0 && gap < 3) gap = 3;
                    tk = tk + gap;
                end
                check({"step_time_", nm}, step_t[bs + k - 1], tk);
            end
            f = tk;
            if (done_t.size() > bd)
                check({"done_time_", nm}, done_t[bd], ((num % se_e) == 0) ? f + 3 : f + 1);
            else
                check({"done_seen_", nm}, 0, 1);
        end
        check({"viol_", nm}, viol - bv, 0);
        check({"step_count_", nm}, step_count, num);
        check({"busy_done_", nm}, {busy, done}, 2'b01);
        rdy_rand = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held_x, new_x0, old_sigma;
        int bh, bd, cnt;
        bit ok;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_sigma = '0; cfg_beta = '0; cfg_rho = '0; cfg_dt = '0;
        cfg_x0 = '0; cfg_y0 = '0; cfg_z0 = '0;
        cfg_step_div = '0; cfg_num_steps = '0; cfg_sample_every = '0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_sol_reset", sol_reset, 1);
        check("rst_sol_step", sol_step, 0);
        check("rst_smp_valid", smp_valid, 0);
        check("rst_smp_x", smp_x, 0);
        check("rst_smp_idx", smp_idx, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_step_count", step_count, 0);
        check("rst_sol_sigma", sol_sigma, 0);

        // Directed: div 3, 8 steps, every 2nd sampled
        do_run(3, 8, 2, 1'b0, 1'b1, "dir1");
        // sample_every=0 behaves as 1
        do_run(1, 5, 0, 1'b0, 1'b1, "se0");

        // Backpressure: ready held low, one sample held stable, nothing lost
        rand_cfg();
        cfg_step_div = '0; cfg_num_steps = 4; cfg_sample_every = 1;
        rdy_lo = 1'b1;
        bh = hs_idx.size();
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        held_x = smp_x;
        for (int i = 0; i < 15; i++) tick();
        check("bp_step_count", step_count, 1);
        check("bp_valid", smp_valid, 1);
        check("bp_idx", smp_idx, 1);
        check("bp_x_stable", smp_x, held_x);
        check("bp_x_value", smp_x, (rx0 + rsg) & MASK);
        rdy_lo = 1'b0;
        wait_done("bp");
        tick();
        check("bp_nsamples", hs_idx.size() - bh, 4);
        for (int i = 0; i < 4 && bh + i < hs_idx.size(); i++)
            check_sample("bp", bh + i, 64'(i + 1));

        // Abort with a sample pending, then start+abort together from IDLE
        rand_cfg();
        cfg_step_div = '0; cfg_num_steps = '0; cfg_sample_every = 1;
        rdy_lo = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) tick();
        check("ab_pending", smp_valid, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("ab_valid", smp_valid, 0);
        check("ab_sol_reset", sol_reset, 1);
        check("ab_busy_done", {busy, done}, 0);
        check("ab_step", sol_step, 0);
        rdy_lo = 1'b0;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_sol_reset", sol_reset, 1);
        tick();
        check("sa_busy2", busy, 0);

        // Free-run: 1000 steps, every 100th sampled, never done
        rand_cfg();
        cfg_step_div = 1; cfg_num_steps = '0; cfg_sample_every = 100;
        bh = hs_idx.size(); bd = done_t.size();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (step_count >= 1000) begin ok = 1'b1; break; end
            tick();
        end
        check("fr_reached", ok, 1);
        for (int i = 0; i < 6; i++) tick();
        cnt = 0;
        for (int i = bh; i < hs_idx.size(); i++) if (hs_idx[i] <= 1000) cnt++;
        check("fr_nsamples", cnt, 10);
        for (int i = 0; i < 10 && bh + i < hs_idx.size(); i++)
            check_sample("fr", bh + i, 64'((i + 1) * 100));
        check("fr_no_done", done_t.size() - bd, 0);
        check("fr_busy", busy, 1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Reset mid-run
        rand_cfg();
        cfg_step_div = '0; cfg_num_steps = '0; cfg_sample_every = '0;
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mr_sol_reset", sol_reset, 1);
        check("mr_smp_valid", smp_valid, 0);
        check("mr_smp_x", smp_x, 0);
        check("mr_smp_idx", smp_idx, 0);
        check("mr_busy_done", {busy, done}, 0);
        check("mr_step_count", step_count, 0);
        check("mr_sol_x0", sol_x0, 0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            bit rr = 1'(r % 2);
            do_run(int'($urandom_range(0, 4)), int'($urandom_range(1, 12)),
                   int'($urandom_range(0, 4)), rr, !rr, $sformatf("rnd%0d", r));
        end

        // Restart from DONE with a new x0; cfg edits while busy are ignored
        new_x0 = W'($urandom);
        cfg_x0 = new_x0;
        old_sigma = cfg_sigma;
        pulse_start();
        check("rs_sol_reset1", sol_reset, 1);
        check("rs_busy", busy, 1);
        check("rs_sol_x0", sol_x0, new_x0);
        check("rs_step_count", step_count, 0);
        cfg_sigma = ~old_sigma;
        tick();
        check("rs_sol_reset2", sol_reset, 1);
        check("rs_sigma_held", sol_sigma, old_sigma);
        tick();
        check("rs_run", sol_reset, 0);
        wait_done("rs");
        abort = 1'b1; tick(); abort = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
